frame_burst_writer: RTL and testbench

FRAME_BURST_WRITER -- requirements
Module: frame_burst_writer

---
 rtl/frame_burst_writer.sv | 258 +++++++++++++++++++++++++
 tb/tb_frame_burst_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_burst_writer.sv
//------------------------------------------------------------------------------
// frame_burst_writer
//
// Collects a frame of 32-bit pixels from an upstream reader stage into a
// power-of-two FIFO and drains it to a memory controller as write bursts of
// up to BURST_LEN words. Bursts walk a byte address pointer that starts at
// BASE_ADDR and advances by 4 bytes per committed word.
//
// Ports
//   clk, rst            : sole clock (rising edge), async active-high reset
//   write_req           : frame-start request (honoured only in IDLE)
//   write_req_ack       : one-cycle acknowledge of write_req
//   write_en/write_data : pixel strobe and pixel word {R,G,B,8'h00}
//   frame_pixels        : pixel count of the frame, sampled at acknowledge
//   wr_burst_req        : burst request, held until the first data pull
//   wr_burst_len        : words in the current burst
//   wr_burst_addr       : byte start address of the current burst
//   wr_burst_data_req   : controller pulls one word this cycle
//   wr_burst_data       : burst word, valid the cycle after its pull
//   wr_burst_finish     : controller pulse, burst committed
//   frame_done          : one-cycle pulse, whole frame committed
//   overflow            : sticky, a pixel was dropped on a full FIFO
//------------------------------------------------------------------------------
module frame_burst_writer #(
  parameter int          FIFO_DEPTH = 64,
  parameter int          BURST_LEN  = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_req,
  output logic              write_req_ack,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic [23:0]       frame_pixels,
  output logic              wr_burst_req,
  output logic [7:0]        wr_burst_len,
  output logic [31:0]       wr_burst_addr,
  input  logic              wr_burst_data_req,
  output logic [DATA_W-1:0] wr_burst_data,
  input  logic              wr_burst_finish,
  output logic              frame_done,
  output logic              overflow
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [23:0] BURST_LEN_W = 24'(BURST_LEN);
  localparam logic [AW:0] DEPTH_W     = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ACK        = 3'd1;
  localparam logic [2:0] S_COLLECT    = 3'd2;
  localparam logic [2:0] S_BURST_REQ  = 3'd3;
  localparam logic [2:0] S_BURST_DATA = 3'd4;
  localparam logic [2:0] S_BURST_WAIT = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  // Burst length for the next burst: the full BURST_LEN, or whatever is
  // left of the frame when that is shorter.
  function automatic logic [7:0] clamp_len(input logic [23:0] remaining);
    if (remaining >= BURST_LEN_W) begin
      return BURST_LEN_W[7:0];
    end
    return remaining[7:0];
  endfunction

  logic [2:0]        state_q, state_d;
  logic [23:0]       frame_px_q, frame_px_d;
  logic [23:0]       in_cnt_q, in_cnt_d;
  logic [23:0]       out_cnt_q, out_cnt_d;
  logic [31:0]       ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        blen_q, blen_d;
  logic [31:0]       baddr_q, baddr_d;
  logic [7:0]        pop_cnt_q, pop_cnt_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] burst_data_p1;

  logic [AW:0]       fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [23:0]       remaining;
  logic [7:0]        next_len;
  logic              frame_active;
  logic              px_valid;
  logic              push;
  logic              pop;
  logic              drop;

  // Stage 0: FIFO status, accept/pop decisions
  always_comb begin
    fifo_cnt     = wr_ptr_q - rd_ptr_q;
    fifo_full    = (fifo_cnt == DEPTH_W);
    fifo_empty   = (fifo_cnt == '0);
    remaining    = frame_px_q - out_cnt_q;
    next_len     = clamp_len(remaining);
    frame_active = (state_q == S_COLLECT)    || (state_q == S_BURST_REQ) ||
                   (state_q == S_BURST_DATA) || (state_q == S_BURST_WAIT);
    px_valid     = frame_active && write_en && (in_cnt_q < frame_px_q);
    pop          = ((state_q == S_BURST_REQ) && wr_burst_data_req) ||
                   ((state_q == S_BURST_DATA) && wr_burst_data_req &&
                    (pop_cnt_q < blen_q));
    // A pop in the same cycle frees a slot, so a full FIFO still takes the word.
    push         = px_valid && (!fifo_full || pop);
    drop         = px_valid && fifo_full && !pop;
  end

  always_comb begin
    state_d    = state_q;
    frame_px_d = frame_px_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    ptr_d      = ptr_q;
    ovf_d      = ovf_q;
    blen_d     = blen_q;
    baddr_d    = baddr_q;
    pop_cnt_d  = pop_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    // A dropped pixel still counts toward the frame, so a lossy frame
    // stalls short of completion instead of absorbing the next frame.
    if (px_valid) begin
      in_cnt_d = in_cnt_q + 24'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (write_req) begin
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        frame_px_d = frame_pixels;
        in_cnt_d   = '0;
        out_cnt_d  = '0;
        ptr_d      = BASE_ADDR;
        ovf_d      = 1'b0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        state_d    = (frame_pixels == 24'd0) ? S_DONE : S_COLLECT;
      end

      S_COLLECT: begin
        // Never issue until the whole burst is buffered: this is what keeps
        // the controller from pulling on an empty FIFO.
        if ((remaining != 24'd0) && (24'(fifo_cnt) >= 24'(next_len))) begin
          blen_d    = next_len;
          baddr_d   = ptr_q;
          pop_cnt_d = '0;
          state_d   = S_BURST_REQ;
        end
      end

      S_BURST_REQ: begin
        if (wr_burst_data_req) begin
          pop_cnt_d = 8'd1;
          state_d   = S_BURST_DATA;
        end
      end

      S_BURST_DATA: begin
        if (pop) begin
          pop_cnt_d = pop_cnt_q + 8'd1;
        end
        if (pop_cnt_d == blen_q) begin
          state_d = S_BURST_WAIT;
        end
      end

      S_BURST_WAIT: begin
        if (wr_burst_finish) begin
          out_cnt_d = out_cnt_q + 24'(blen_q);
          ptr_d     = ptr_q + 32'({blen_q, 2'b00});
          state_d   = ((out_cnt_q + 24'(blen_q)) == frame_px_q) ? S_DONE : S_COLLECT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage 0 -> 1: control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_px_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      blen_q     <= '0;
      baddr_q    <= '0;
      pop_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      frame_px_q <= frame_px_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      blen_q     <= blen_d;
      baddr_q    <= baddr_d;
      pop_cnt_q  <= pop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Stage 0 -> 1: FIFO storage, no reset needed on pure data
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= write_data;
    end
  end

  // Stage 1: burst output word, one cycle behind its pull; holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_data_p1 <= '0;
    end else if (pop) begin
      burst_data_p1 <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign write_req_ack = (state_q == S_ACK);
  assign wr_burst_req  = (state_q == S_BURST_REQ);
  assign frame_done    = (state_q == S_DONE);
  assign overflow      = ovf_q;
  assign wr_burst_len  = blen_q;
  assign wr_burst_addr = baddr_q;
  assign wr_burst_data = burst_data_p1;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));

endmodule

// File: tb/tb_frame_burst_writer.sv
module tb_frame_burst_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_req;
  logic        write_req_ack;
  logic        write_en;
  logic [31:0] write_data;
  logic [23:0] frame_pixels;
  logic        wr_burst_req;
  logic [7:0]  wr_burst_len;
  logic [31:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish;
  logic        frame_done;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;

  int done_cnt = 0;
  int breq_cnt = 0;
  logic breq_prev = 1'b0;

  int stall = 0;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_len[$];
  logic [31:0] cap_data[$];

  frame_burst_writer dut (
    .clk               (clk),
    .rst               (rst),
    .write_req         (write_req),
    .write_req_ack     (write_req_ack),
    .write_en          (write_en),
    .write_data        (write_data),
    .frame_pixels      (frame_pixels),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_addr     (wr_burst_addr),
    .wr_burst_data_req (wr_burst_data_req),
    .wr_burst_data     (wr_burst_data),
    .wr_burst_finish   (wr_burst_finish),
    .frame_done        (frame_done),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix(input int i);
    return {8'(i + 1), 8'(255 - i), 8'(i * 7 + 3), 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse counters sampled on the rising edge (values of the ending cycle).
  always @(posedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (wr_burst_req === 1'b1 && !breq_prev) breq_cnt++;
    breq_prev = (wr_burst_req === 1'b1);
  end

  // Memory controller model: optional stall, then pulls len words back to
  // back, captures each word the cycle after its pull, then finishes.
  initial begin : ctrl
    int  b_len;
    bit  aborted;
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && wr_burst_req) begin
        aborted = 1'b0;
        b_len   = int'(wr_burst_len);
        cap_addr.push_back(wr_burst_addr);
        cap_len.push_back(32'(wr_burst_len));
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
        end
        for (int k = 0; k < b_len; k++) begin
          if (aborted) break;
          wr_burst_data_req = 1'b1;
          @(negedge clk);
          if (rst) aborted = 1'b1;
          else cap_data.push_back(wr_burst_data);
        end
        wr_burst_data_req = 1'b0;
        if (!aborted) begin
          @(negedge clk);
          @(negedge clk);
          wr_burst_finish = 1'b1;
          @(negedge clk);
          wr_burst_finish = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack",   32'(write_req_ack), 32'd0);
    chk("rst_breq",  32'(wr_burst_req),  32'd0);
    chk("rst_done",  32'(frame_done),    32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    chk("rst_len",   32'(wr_burst_len),  32'd0);
    chk("rst_addr",  wr_burst_addr,      32'd0);
    chk("rst_data",  wr_burst_data,      32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_frame(input logic [23:0] n);
    frame_pixels = n;
    write_req    = 1'b1;
    @(negedge clk);
    chk("ack_hi", 32'(write_req_ack), 32'd1);
    write_req = 1'b0;
    @(negedge clk);
    chk("ack_lo", 32'(write_req_ack), 32'd0);
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      write_en   = 1'b1;
      write_data = pix(i);
      @(negedge clk);
    end
    write_en   = 1'b0;
    write_data = 32'h0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int c;
    c = 0;
    while ((done_cnt - base) < 1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_data(input string tag, input int base, input int n);
    chk({tag, "_nwords"}, 32'(cap_data.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      chk({tag, "_word"}, (base + k < cap_data.size()) ? cap_data[base + k] : 32'hxxxx_xxxx, pix(k));
    end
  endtask

  initial begin : main
    int bb, bd, dn, br, c;
    rst          = 1'b1;
    write_req    = 1'b0;
    write_en     = 1'b0;
    write_data   = 32'h0;
    frame_pixels = 24'd0;
    do_reset();

    // 32 pixels, immediate pulls: two full bursts
    bb = cap_addr.size(); bd = cap_data.size(); dn = done_cnt;
    start_frame(24'd32);
    send_pixels(32);
    wait_done(dn, 300);
    chk("f32_nburst", 32'(cap_addr.size() - bb), 32'd2);
    chk("f32_addr0",  cap_addr[bb],     32'h0);
    chk("f32_len0",   cap_len[bb],      32'd16);
    chk("f32_addr1",  cap_addr[bb + 1], 32'h40);
    chk("f32_len1",   cap_len[bb + 1],  32'd16);
    chk("f32_done",   32'(done_cnt - dn), 32'd1);
    chk("f32_ovf",    32'(overflow),    32'd0);
    check_data("f32", bd, 32);

    // 20 pixels: full burst then a 4-word tail
    bb = cap_addr.size(); bd = cap_data.size(); dn = done_cnt;
    start_frame(24'd20);
    send_pixels(20);
    wait_done(dn, 300);
    chk("f20_nburst", 32'(cap_addr.size() - bb), 32'd2);
    chk("f20_addr0",  cap_addr[bb],     32'h0);
    chk("f20_len0",   cap_len[bb],      32'd16);
    chk("f20_addr1",  cap_addr[bb + 1], 32'h40);
    chk("f20_len1",   cap_len[bb + 1],  32'd4);
    chk("f20_done",   32'(done_cnt - dn), 32'd1);
    check_data("f20", bd, 20);

    // Empty frame: ack, then done the next cycle, no burst
    br = breq_cnt; dn = done_cnt;
    start_frame(24'd0);
    chk("f0_done_hi", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("f0_done_lo", 32'(frame_done), 32'd0);
    repeat (5) @(negedge clk);
    chk("f0_ndone",   32'(done_cnt - dn), 32'd1);
    chk("f0_nbreq",   32'(breq_cnt - br), 32'd0);

    // Strobes in IDLE/ACK and 5 beyond the frame are ignored
    bb = cap_addr.size(); bd = cap_data.size(); dn = done_cnt;
    write_en   = 1'b1;
    write_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    start_frame(24'd16);
    send_pixels(21);
    wait_done(dn, 300);
    chk("ext_nburst", 32'(cap_addr.size() - bb), 32'd1);
    chk("ext_addr0",  cap_addr[bb], 32'h0);
    chk("ext_len0",   cap_len[bb],  32'd16);
    chk("ext_done",   32'(done_cnt - dn), 32'd1);
    chk("ext_ovf",    32'(overflow), 32'd0);
    check_data("ext", bd, 16);

    // Stalled controller: 64 buffer, the 65th pixel overflows, never done
    dn = done_cnt;
    stall = 100;
    start_frame(24'd200);
    for (int i = 0; i < 200; i++) begin
      write_en   = 1'b1;
      write_data = pix(i);
      @(negedge clk);
      if (i == 63) chk("ovf_at64", 32'(overflow), 32'd0);
      if (i == 64) chk("ovf_at65", 32'(overflow), 32'd1);
    end
    write_en = 1'b0;
    repeat (400) @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_nodone", 32'(done_cnt - dn), 32'd0);
    do_reset();
    stall = 0;

    // Reset in the middle of a burst data phase
    bd = cap_data.size();
    start_frame(24'd32);
    send_pixels(16);
    c = 0;
    while ((cap_data.size() - bd) < 4 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_indata", 32'(wr_burst_data_req), 32'd1);
    do_reset();
    br = breq_cnt;
    repeat (10) @(negedge clk);
    chk("midrst_nobreq", 32'(breq_cnt - br), 32'd0);
    bb = cap_addr.size(); bd = cap_data.size(); dn = done_cnt;
    start_frame(24'd16);
    send_pixels(16);
    wait_done(dn, 300);
    chk("post_nburst", 32'(cap_addr.size() - bb), 32'd1);
    chk("post_addr0",  cap_addr[bb], 32'h0);
    chk("post_len0",   cap_len[bb],  32'd16);
    chk("post_done",   32'(done_cnt - dn), 32'd1);
    check_data("post", bd, 16);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
